// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage and a carry register walk the operands LSB first.
// A three-state controller (idle, run, done) sequences capture, WIDTH add cycles and a done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic bit_a, bit_b, sum_bit, carry_out, last_bit;

  // Single full-adder stage fed by the bit selected by the counter.
  assign bit_a     = a_q[cnt_q];
  assign bit_b     = b_q[cnt_q];
  assign sum_bit   = bit_a ^ bit_b ^ carry_q;
  assign carry_out = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    ov_d    = ov_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          s_d     = '0;
        end
      end
      StRun: begin
        s_d[cnt_q] = sum_bit;
        carry_d    = carry_out;
        if (last_bit) begin
          // carry_q is the carry into the MSB here, so it yields the overflow term.
          co_d    = carry_out;
          ov_d    = carry_q ^ carry_out;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign co   = co_q;
  assign ov   = ov_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, ci;
  logic [W-1:0] a, b;
  logic         busy, done, co, ov;
  logic [W-1:0] s;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .ci   (ci),
    .busy (busy),
    .done (done),
    .s    (s),
    .co   (co),
    .ov   (ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ov, co, s} from plain integer addition and sign rules.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {o, t[W], t[W-1:0]};
  endfunction

  // One complete addition; noisy=1 toggles start and scrambles operands during the run.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                       input bit noisy, input logic [W-1:0] es, input logic eco,
                       input logic eov);
    @(negedge clk);
    a = ta; b = tb_v; ci = tci; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      start = noisy ? 1'($urandom) : 1'b0;
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", s, es);
    check("carry_out", co, eco);
    check("overflow", ov, eov);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("hold_s", s, es);
      check("hold_co", co, eco);
      check("hold_ov", ov, eov);
    end
  endtask

  initial begin
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    logic         rc;
    bit           exp_busy, exp_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_co", co, 0);
    check("rst_ov", ov, 0);

    // start together with rst must be ignored
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    check("rst_start_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);

    // start held high: runs accepted every W+2 cycles, mid-run operand change ignored
    @(negedge clk);
    a = 8'h01; b = 8'h02; ci = 1'b0; start = 1'b1;
    for (int k = 1; k <= 2 * (W + 2); k++) begin
      @(negedge clk);
      if (k == 3) begin a = 8'h10; b = 8'h20; end
      exp_busy = (k >= 1 && k <= W) || (k >= W + 3 && k <= 2 * W + 2);
      exp_done = (k == W + 1) || (k == 2 * W + 3);
      check("held_busy", busy, 32'(exp_busy));
      check("held_done", done, 32'(exp_done));
      if (k == W + 1)     check("held_sum1", s, 8'h03);
      if (k == 2 * W + 3) check("held_sum2", s, 8'h30);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // reset on the 4th run cycle aborts with no done pulse
    a = 8'hA5; b = 8'h5A; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_s", s, 0);
    check("abort_co", co, 0);
    check("abort_ov", ov, 0);
    for (int k = 0; k < W + 2; k++) begin
      check("abort_no_done", done, 0);
      @(negedge clk);
    end
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (n == 0) begin ra = 8'h7F; rb = 8'h00; rc = 1'b1; end
      r = ref_add(ra, rb, rc);
      do_op(ra, rb, rc, n[0], r[W-1:0], r[W], r[W+1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
